// File: rtl/system_bus_ctrl.sv
// Fetch/execute sequencer for the single-bus CPU datapath: drives bus mux select,
// register load/increment strobes and memory reads, with a fetch timeout and instruction counter.
module system_bus_ctrl #(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        halt,
  input  logic        mem_ack,
  input  logic        exec_done,
  input  logic        err_clr,
  output logic [1:0]  bus_sel,
  output logic        ar_ld,
  output logic        dr_ld,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        mem_rd,
  output logic        exec_start,
  output logic        busy,
  output logic        bus_err,
  output logic [15:0] instr_cnt
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT - 1);

  localparam logic [1:0] SEL_PC  = 2'd0;
  localparam logic [1:0] SEL_DR  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;

  // N only documents the datapath width this sequencer is paired with.
  if (N == 0) begin : g_zero_width_bus
  end

  typedef enum logic [2:0] {IDLE, F1, F2, F3, EXEC, ERR} state_t;

  state_t        state, next_state;
  logic [WW-1:0] wait_cnt;
  logic          exec_first;
  logic          done_ok;

  // exec_done is only honoured from the second EXEC cycle onward.
  assign done_ok = (state == EXEC) && !exec_first && exec_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      exec_first <= 1'b0;
      instr_cnt  <= '0;
    end else begin
      state      <= next_state;
      exec_first <= (state == F3);
      if (state != F2)
        wait_cnt <= '0;
      else if (!mem_ack)
        wait_cnt <= wait_cnt + WW'(1);
      if (done_ok)
        instr_cnt <= instr_cnt + 16'd1;
    end
  end

  always_comb begin
    next_state = state;
    bus_sel    = SEL_PC;
    ar_ld      = 1'b0;
    dr_ld      = 1'b0;
    ir_ld      = 1'b0;
    pc_inc     = 1'b0;
    mem_rd     = 1'b0;
    exec_start = 1'b0;
    busy       = 1'b1;
    bus_err    = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (run && !halt)
          next_state = F1;
      end
      F1: begin
        ar_ld      = 1'b1;
        next_state = F2;
      end
      F2: begin
        bus_sel = SEL_MEM;
        mem_rd  = 1'b1;
        // An ack on the final allowed wait cycle still wins over the timeout.
        if (mem_ack) begin
          dr_ld      = 1'b1;
          pc_inc     = 1'b1;
          next_state = F3;
        end else if (wait_cnt == LAST_WAIT) begin
          next_state = ERR;
        end
      end
      F3: begin
        bus_sel    = SEL_DR;
        ir_ld      = 1'b1;
        ar_ld      = 1'b1;
        next_state = EXEC;
      end
      EXEC: begin
        bus_sel    = SEL_DR;
        exec_start = exec_first;
        if (done_ok)
          next_state = (halt || !run) ? IDLE : F1;
      end
      ERR: begin
        busy    = 1'b0;
        bus_err = 1'b1;
        if (err_clr)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
